pov_col_scan: RTL
=================

Name: pov_col_scan

Overview:
- Column scan sequencer for the rotating POV LED display.
- Synchronises to the hall-sensor index pulse and measures the rotation period in `clk` cycles.
- Splits each revolution into N_COLS equal column slots. Per slot it drives the column read address (`dir`) and the read-select (`leer_ram`) into the downstream RAM address mux, then latches the returned RAM byte onto the LED column.
- Outside read windows it grants RAM access to the ASCII writer.

Parameters:
- N_COLS, 128, columns per revolution; must be a power of two, at most 2**ADDR_W.
- ADDR_W, 8, width of the column address.
- CNT_W, 20, width of the period counter.
- MIN_SLOT, 4, minimum legal slot length in clk cycles; shorter periods are rejected.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hall_in  in  1  raw hall-sensor index, asynchronous, active-high pulse once per revolution
- ram_data  in  8  RAM read data, valid one cycle after dir is presented with leer_ram=1
- wr_req  in  1  ASCII writer requests a RAM write cycle
- dir  out  ADDR_W  column read address to the RAM address mux
- leer_ram  out  1  1 = RAM address mux selects dir (read for display), 0 = writer address
- wr_gnt  out  1  writer may write this cycle
- leds  out  8  current LED column pattern
- period_valid  out  1  a legal rotation period is locked

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, period register 0.
- hall_in handling:
  - Passes through a 2-FF synchroniser, then a rising-edge detector.
  - `hall_edge` is a 1-cycle pulse, 3 cycles after the raw edge.
- Period counter:
  - Increments every cycle and saturates at 2**CNT_W-1.
  - On hall_edge: `period_reg` <= counter, counter <= 1 in the same cycle.
  - Slot length = `period_reg` >> log2(N_COLS); the remainder is discarded.
- Legality:
  - The period is legal iff the counter has not saturated and slot length >= MIN_SLOT.
  - `period_valid` = 1 while the FSM is in SCAN or BLANK.
- FSM states:
  - IDLE: waiting for the first edge, leds=0. Transition: hall_edge -> SYNC.
  - SYNC: measuring one full revolution. Transition: hall_edge with a legal period -> SCAN at column 0. Transition: counter saturates -> IDLE.
  - SCAN: stepping through columns.
    - Slot timer reloads with slot length at each column start.
    - Column advance happens on timer expiry.
    - After column N_COLS-1 expires -> BLANK.
  - BLANK: leds=0, waiting for the index.
    - hall_edge with a legal period -> SCAN at column 0.
    - hall_edge with an illegal period -> IDLE.
    - Counter saturates -> IDLE.
  - Any hall_edge while in SCAN restarts column 0 with the new period if it is legal, otherwise -> IDLE (leds=0). This covers a spin-up or slow-down mid-revolution.
- Read window, per column start:
  - Cycle 0: `dir`=column, `leer_ram`=1.
  - Cycle 1: `leer_ram`=1; leds <= ram_data at the end of the cycle.
  - Then `leer_ram`=0 and `dir` holds its value.
  - Read latency column-start -> leds updated = 2 cycles.
- Writer arbitration:
  - wr_gnt = wr_req & ~leer_ram, combinational from registered `leer_ram`.
  - A read always wins over a write; a writer that is denied simply retries.
  - In IDLE and SYNC, wr_gnt = wr_req.
- Simultaneous events:
  - hall_edge in the same cycle as slot expiry: hall_edge wins and the next column is 0.
  - hall_edge during a read window: the window is aborted and a new window opens for column 0 on the next cycle. leds keep their previous value until that window completes.
- Column index wraps only through BLANK, never modulo.
- rst_n asserted mid-scan: immediate return to the reset values above.

Decomposition:
- Shared package `pov_pkg`:
  - FSM state enum (IDLE, SYNC, SCAN, BLANK).
  - Constants LED_W=8, ADDR_W default, log2 helper for N_COLS.
- One natural sub-module: `hall_sync`, the 2-FF synchroniser plus rising-edge detector, reusable for other asynchronous sensor inputs.
- Period counter, slot timer, FSM and read window live in the top module.

Test Plan:
1. Reset, then hall pulses every 12800 cycles (N_COLS=128) -> SYNC after the 1st pulse, SCAN after the 2nd. Slot length=100. `dir` steps 0..127 every 100 cycles. leds = RAM[dir] 2 cycles after each step. BLANK is never entered.
2. Preload RAM[c]=c^8'hA5; pulses every 13000 cycles -> slot length 101. The last column ends at cycle 12928, then BLANK with leds=0 until the edge at 13000, then column 0 again.
3. Pulses every 256 cycles (slot 2 < MIN_SLOT) -> remains in SYNC/IDLE with period_valid=0. leds stay 0 and `leer_ram` is never 1.
4. During SCAN, hold wr_req=1 continuously -> wr_gnt=0 exactly in the 2 leer_ram cycles per column and 1 in every other cycle. No read is ever displaced.
5. Stop the hall pulses while in SCAN -> column 127 completes, then BLANK. When the counter saturates -> IDLE with period_valid=0 and leds=0.
6. Assert a hall pulse mid-column 40 and in the same cycle as a slot expiry -> the next `dir` is 0 in both cases, with the read window restarted. Assert rst_n=0 mid-read -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared definitions for the POV column scan sequencer: FSM states,
// display constants and a constant-evaluation log2 helper.
package pov_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // no index seen yet
    SYNC  = 2'd1,   // measuring the first full revolution
    SCAN  = 2'd2,   // stepping through columns
    BLANK = 2'd3    // all columns shown, waiting for the next index
  } pov_state_e;

  // Width of one LED column / one RAM byte
  localparam int LED_W = 8;

  // Default column address width
  localparam int ADDR_W_DEF = 8;

  // Ceiling log2, intended for elaboration-time constants only
  // (e.g. the shift that turns a period into a slot length).
  function automatic int pov_log2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hall_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for an
// asynchronous sensor input. rise_o is a single-cycle pulse that appears
// three clocks after the raw edge.
module hall_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchroniser chain, delayed copy and edge pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/pov_col_scan.sv
// Column scan sequencer for the rotating POV display. Measures the
// rotation period between hall index pulses, divides a revolution into
// N_COLS equal slots, opens a two-cycle RAM read window at the start of
// every slot and shows the returned byte on the LED column. The RAM is
// handed to the ASCII writer whenever no read window is open.
// N_COLS must be a power of two no larger than 2**ADDR_W.
module pov_col_scan
  import pov_pkg::*;
#(
  parameter int N_COLS   = 128,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = 20,
  parameter int MIN_SLOT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hall_in,
  input  logic [LED_W-1:0]  ram_data,
  input  logic              wr_req,
  output logic [ADDR_W-1:0] dir,
  output logic              leer_ram,
  output logic              wr_gnt,
  output logic [LED_W-1:0]  leds,
  output logic              period_valid
);

  localparam int                COL_SHIFT  = pov_log2(N_COLS);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_SLOT_C = CNT_W'(MIN_SLOT);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(N_COLS - 1);
  localparam logic [ADDR_W-1:0] COL_ONE    = ADDR_W'(1);

  // ---------------------------------------------------------------
  // Index pulse
  // ---------------------------------------------------------------
  logic hall_edge;

  hall_sync u_hall_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (hall_in),
    .rise_o (hall_edge)
  );

  // ---------------------------------------------------------------
  // Period measurement
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             cnt_sat;
  logic [CNT_W-1:0] meas_slot;   // slot length of the revolution just measured
  logic [CNT_W-1:0] run_slot;    // slot length of the revolution being shown
  logic             period_legal;

  assign cnt_sat      = (cnt_q == CNT_MAX);
  assign meas_slot    = cnt_q >> COL_SHIFT;
  assign run_slot     = period_q >> COL_SHIFT;
  // A saturated counter means the wheel is too slow to measure; a short
  // slot leaves no room for the read window.
  assign period_legal = !cnt_sat && (meas_slot >= MIN_SLOT_C);

  // Period counter: restart at 1 on the index, otherwise count and stick at max
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (hall_edge) begin
      period_d = cnt_q;
      cnt_d    = CNT_ONE;
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Period counter and captured period registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  // ---------------------------------------------------------------
  // Scan FSM, slot timer and read window
  // ---------------------------------------------------------------
  pov_state_e        state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              rd_first_q, rd_first_d;    // window cycle 0: address out
  logic              rd_second_q, rd_second_d;  // window cycle 1: data back
  logic [LED_W-1:0]  leds_q, leds_d;

  logic              start_col;
  logic [ADDR_W-1:0] start_idx;
  logic [CNT_W-1:0]  start_len;

  // Next-state logic: transitions, column stepping and LED latching
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    timer_d     = timer_q;
    rd_first_d  = 1'b0;
    rd_second_d = rd_first_q;
    leds_d      = leds_q;
    start_col   = 1'b0;
    start_idx   = '0;
    start_len   = meas_slot;

    // Second window cycle: the RAM byte for this column is on ram_data
    if (rd_second_q) begin
      leds_d = ram_data;
    end

    unique case (state_q)
      IDLE: begin
        leds_d      = '0;
        rd_second_d = 1'b0;
        if (hall_edge) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        leds_d      = '0;
        rd_second_d = 1'b0;
        if (hall_edge) begin
          // An illegal first period just keeps measuring
          if (period_legal) begin
            start_col = 1'b1;
          end
        end else if (cnt_sat) begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        if (hall_edge) begin
          // The index always re-anchors column 0, even mid-slot
          if (period_legal) begin
            start_col = 1'b1;
          end else begin
            state_d     = IDLE;
            leds_d      = '0;
            rd_second_d = 1'b0;
          end
        end else if (timer_q == '0) begin
          if (col_q == LAST_COL) begin
            // Wrap only through BLANK so column 0 stays tied to the index
            state_d     = BLANK;
            leds_d      = '0;
            rd_second_d = 1'b0;
          end else begin
            start_col = 1'b1;
            start_idx = col_q + COL_ONE;
            start_len = run_slot;
          end
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end

      BLANK: begin
        leds_d      = '0;
        rd_second_d = 1'b0;
        if (hall_edge) begin
          if (period_legal) begin
            start_col = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_sat) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        leds_d      = '0;
        rd_second_d = 1'b0;
      end
    endcase

    // Column start: present the address and open a fresh window. An
    // in-flight window is abandoned, so the LEDs keep their old pattern.
    if (start_col) begin
      state_d     = SCAN;
      col_d       = start_idx;
      timer_d     = start_len - CNT_ONE;
      rd_first_d  = 1'b1;
      rd_second_d = 1'b0;
      leds_d      = leds_q;
    end
  end

  // State, column, timer, window and LED registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      timer_q     <= '0;
      rd_first_q  <= 1'b0;
      rd_second_q <= 1'b0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      rd_first_q  <= rd_first_d;
      rd_second_q <= rd_second_d;
      leds_q      <= leds_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign dir          = col_q;
  assign leer_ram     = rd_first_q | rd_second_q;
  // Reads always win; a denied writer retries on a later cycle
  assign wr_gnt       = wr_req & ~leer_ram;
  assign leds         = leds_q;
  assign period_valid = (state_q == SCAN) || (state_q == BLANK);

endmodule
